// File: rtl/ifmap_stream_tx.sv
// ifmap_stream_tx: fetches IFMap rows from a word-addressed SRAM (1-cycle read
// latency) and streams them as {tag, data} words into the Conv IF buffer.
// Tags: 2'b10 first, 2'b01 last, 2'b11 single-word row, 2'b00 interior.
// Optional feature macro: IFMAP_TX_STRIDE_EN adds a row_stride port; without it
// rows are contiguous (row step = row_len).
module ifmap_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
`ifdef IFMAP_TX_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] row_stride,
`endif
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH+1:0] IFMap,
  output logic                  IF_buff_wen,
  input  logic                  IF_buff_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                 state, state_nx;

  // Transfer descriptor latched on the start edge
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   rows_q;
  logic [ADDR_WIDTH-1:0]  step_q;

  // Fetch-side position and address accumulators
  logic [LEN_WIDTH-1:0]   f_word;
  logic [LEN_WIDTH-1:0]   f_row;
  logic [ADDR_WIDTH-1:0]  row_addr;
  logic [ADDR_WIDTH-1:0]  word_addr;

  // Read in flight: data returns on the next cycle
  logic                   rd_vld_p1;
  logic                   rd_first_p1;
  logic                   rd_last_p1;

  // Two-entry skid FIFO holding {tag, data}
  logic [EW-1:0]          fifo_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fifo_cnt;

  logic                   start_ok;
  logic                   start_empty;
  logic                   fetch_left;
  logic                   last_in_row;
  logic                   pop;
  logic [2:0]             occ;
  logic                   issue;
  logic                   last_hs;

  assign start_ok    = (state == S_IDLE) && start;
  assign start_empty = (row_len == '0) || (num_rows == '0);
  assign fetch_left  = (f_row != rows_q);
  assign last_in_row = (f_word == len_q - LEN_WIDTH'(1));
  assign pop         = (fifo_cnt != 2'd0) && IF_buff_ready;
  assign occ         = 3'(fifo_cnt) + 3'(rd_vld_p1) - 3'(pop);
  assign issue       = (state == S_RUN) && fetch_left && (occ < 3'd2);
  assign last_hs     = pop && !fetch_left && !rd_vld_p1 && (fifo_cnt == 2'd1);

  assign mem_ren     = issue;
  assign mem_addr    = word_addr;
  assign IF_buff_wen = (fifo_cnt != 2'd0);
  assign IFMap       = IF_buff_wen ? fifo_mem[rd_ptr] : '0;
  assign busy        = (state == S_RUN);
  assign done        = (state == S_FINISH);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = start_empty ? S_FINISH : S_RUN;
      S_RUN:    if (last_hs) state_nx = S_FINISH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Descriptor latch and row-major fetch address generation
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q     <= '0;
      rows_q    <= '0;
      step_q    <= '0;
      f_word    <= '0;
      f_row     <= '0;
      row_addr  <= '0;
      word_addr <= '0;
    end else if (start_ok) begin
      len_q     <= row_len;
      rows_q    <= num_rows;
`ifdef IFMAP_TX_STRIDE_EN
      step_q    <= row_stride;
`else
      step_q    <= ADDR_WIDTH'(row_len);
`endif
      f_word    <= '0;
      f_row     <= '0;
      row_addr  <= base_addr;
      word_addr <= base_addr;
    end else if (issue) begin
      if (last_in_row) begin
        f_word    <= '0;
        f_row     <= f_row + LEN_WIDTH'(1);
        row_addr  <= row_addr + step_q;
        word_addr <= row_addr + step_q;
      end else begin
        f_word    <= f_word + LEN_WIDTH'(1);
        word_addr <= word_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Stage p0 -> p1: row-position flags travel with the outstanding read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_p1   <= 1'b0;
      rd_first_p1 <= 1'b0;
      rd_last_p1  <= 1'b0;
    end else begin
      rd_vld_p1   <= issue;
      rd_first_p1 <= (f_word == '0);
      rd_last_p1  <= last_in_row;
    end
  end

  // Stage p1 -> FIFO: capture returning read data with its tag
  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[wr_ptr] <= {rd_first_p1, rd_last_p1, mem_rdata};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (rd_vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)       rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_vld_p1) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ifmap_stream_tx.sv
// Directed bench for ifmap_stream_tx with a 1-cycle-latency SRAM model.
module tb_ifmap_stream_tx;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] row_len = '0;
  logic [LW-1:0] num_rows = '0;
  logic [AW-1:0] row_stride = '0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW+1:0] IFMap;
  logic          IF_buff_wen;
  logic          IF_buff_ready = 1'b1;
  logic          busy;
  logic          done;

  logic [DW-1:0] sram [256];
  int n_cmp = 0;
  int n_err = 0;

  ifmap_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .row_len(row_len), .num_rows(num_rows),
`ifdef IFMAP_TX_STRIDE_EN
    .row_stride(row_stride),
`endif
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .IFMap(IFMap), .IF_buff_wen(IF_buff_wen), .IF_buff_ready(IF_buff_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model: data valid the cycle after the read enable
  always @(posedge clk) if (mem_ren) mem_rdata <= sram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_mem_ren"}, 32'(mem_ren), 0);
    chk({nm, "_mem_addr"}, 32'(mem_addr), 0);
    chk({nm, "_ifmap"}, 32'(IFMap), 0);
    chk({nm, "_wen"}, 32'(IF_buff_wen), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
  endtask

  // One transfer; cycle k is the cycle after the k-th edge following E0.
  task automatic run_xfer(input logic [7:0] base, input logic [7:0] len,
                          input logic [7:0] rows, input bit rnd,
                          input int exp_first, input int exp_done,
                          input int abort_after, input string nm);
    logic [31:0] pat;
    logic [17:0] exp_q[$];
    logic [7:0]  exp_a[$];
    logic [17:0] got[$];
    logic [7:0]  addrs[$];
    logic [17:0] prev_map;
    logic [7:0]  a;
    bit          prev_stall;
    int          first_cyc, last_cyc, done_cyc, done_cnt;
    pat = 32'h6B2D4E99;
    prev_stall = 0; prev_map = '0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    for (int r = 0; r < int'(rows); r++)
      for (int i = 0; i < int'(len); i++) begin
        a = 8'(int'(base) + r * int'(len) + i);
        exp_a.push_back(a);
        exp_q.push_back({(i == 0), (i == int'(len) - 1), sram[a]});
      end

    @(posedge clk); #1;
    base_addr = base; row_len = len; num_rows = rows; row_stride = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~base; row_len = 8'd3; num_rows = 8'd7; row_stride = 8'd9;
    for (int k = 1; k <= 150; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      IF_buff_ready = rnd ? pat[k % 32] : 1'b1;
      @(negedge clk);
      if (k == 1) chk({nm, "_busy_c1"}, 32'(busy), 32'((len != 0) && (rows != 0)));
      if (prev_stall) begin
        chk($sformatf("%s_hold_wen_c%0d", nm, k), 32'(IF_buff_wen), 1);
        chk($sformatf("%s_hold_data_c%0d", nm, k), 32'(IFMap), 32'(prev_map));
      end
      prev_stall = IF_buff_wen && !IF_buff_ready;
      prev_map = IFMap;
      if (mem_ren) addrs.push_back(mem_addr);
      if (IF_buff_wen && first_cyc < 0) first_cyc = k;
      if (IF_buff_wen && IF_buff_ready) begin got.push_back(IFMap); last_cyc = k; end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k;
          chk({nm, "_busy_at_done"}, 32'(busy), 0);
        end
      end
      if (abort_after > 0 && got.size() == abort_after) begin
        for (int j = 0; j < abort_after; j++)
          chk($sformatf("%s_pre_w%0d", nm, j), 32'(got[j]), 32'(exp_q[j]));
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk_reset_outputs({nm, "_rst"});
        @(posedge clk); @(posedge clk); @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_post_rst_wen"}, 32'(IF_buff_wen), 0);
        chk({nm, "_post_rst_busy"}, 32'(busy), 0);
        return;
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end

    chk({nm, "_n_words"}, got.size(), exp_q.size());
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      chk($sformatf("%s_w%0d", nm, j), 32'(got[j]), 32'(exp_q[j]));
    chk({nm, "_n_reads"}, addrs.size(), exp_a.size());
    for (int j = 0; j < addrs.size() && j < exp_a.size(); j++)
      chk($sformatf("%s_a%0d", nm, j), 32'(addrs[j]), 32'(exp_a[j]));
    chk({nm, "_done_cnt"}, done_cnt, 1);
    if (exp_done >= 0) chk({nm, "_done_cyc"}, done_cyc, exp_done);
    if (!rnd) begin
      chk({nm, "_first_cyc"}, first_cyc, exp_first);
      if (exp_q.size() > 0) chk({nm, "_no_bubble"}, last_cyc, first_cyc + exp_q.size() - 1);
    end
    IF_buff_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] t1 [10];
    t1 = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'hFFFF,
           16'hFFFE, 16'h0002, 16'h0000, 16'h0001, 16'h0001};
    for (int i = 0; i < 256; i++) sram[i] = 16'(i);
    for (int i = 0; i < 10; i++) sram[i] = t1[i];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk);

    // Single 10-word row of signed values
    run_xfer(8'd0, 8'd10, 8'd1, 1'b0, 3, 13, 0, "c1");
    for (int i = 0; i < 10; i++) sram[i] = 16'(i);
    // Three rows of four, ready high then pseudo-random ready
    run_xfer(8'd0, 8'd4, 8'd3, 1'b0, 3, 15, 0, "c2");
    run_xfer(8'd0, 8'd4, 8'd3, 1'b1, -1, -1, 0, "c3");
    // Single-word rows
    run_xfer(8'd0, 8'd1, 8'd2, 1'b0, 3, 5, 0, "c4");
    // Empty transfer
    run_xfer(8'd0, 8'd0, 8'd3, 1'b0, -1, 1, 0, "c5");
    // Address wrap, aborted by reset, then a full rerun
    run_xfer(8'd254, 8'd4, 8'd1, 1'b0, 3, 7, 2, "c6a");
    run_xfer(8'd254, 8'd4, 8'd1, 1'b0, 3, 7, 0, "c6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
